// File: rtl/sobel_3x3_edge_gray8.sv
// Streaming 3x3 Sobel edge detector for 8-bit grayscale pixels: two line buffers, a 3x3 window and a
// two-stage gradient/magnitude pipeline. Define SOBEL_DIR_EN to add the edge_dir direction-class output.
module sobel_3x3_edge_gray8 #(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int COORD_W = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       pixel_valid,
  input  logic [7:0] pixel_in,
  input  logic [7:0] threshold,
  output logic       edge_valid,
  output logic [7:0] edge_out,
  output logic       edge_bit
`ifdef SOBEL_DIR_EN
  ,
  output logic [1:0] edge_dir
`endif
);

  logic [COORD_W-1:0] r_x, r_y;
  logic [7:0]         r_lb0 [IMG_W];   // line y-2
  logic [7:0]         r_lb1 [IMG_W];   // line y-1
  logic [7:0]         r_win [3][3];    // [row][col], row 0 oldest, col 0 leftmost
  logic [7:0]         r_win_thr;
  logic               r_win_valid;
  logic signed [10:0] r_gx, r_gy;
  logic [7:0]         r_s1_thr;
  logic               r_s1_valid;

  logic               w_accept;
  logic               w_x_last, w_y_last;
  logic               w_interior;
  logic [7:0]         w_col [3];
  logic signed [10:0] w_gx, w_gy;
  logic [10:0]        w_abs_gx, w_abs_gy, w_mag;
  logic [7:0]         w_sat;
  logic               w_over;

  function automatic logic signed [10:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c);
    return $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
  endfunction

  assign w_accept   = pixel_valid & ~vsync;
  assign w_x_last   = (r_x == COORD_W'(IMG_W - 1));
  assign w_y_last   = (r_y == COORD_W'(IMG_H - 1));
  assign w_interior = (r_x >= COORD_W'(2)) && (r_y >= COORD_W'(2));

  always_comb begin
    w_col[0] = r_lb0[r_x];
    w_col[1] = r_lb1[r_x];
    w_col[2] = pixel_in;
  end

  // Raster counters; the frame wraps on its own at the last pixel, vsync forces a restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
      r_x <= '0;
      r_y <= '0;
    end else if (vsync) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // NOTE: line buffers and window data carry no reset; the valid pipeline guarantees stale data is never emitted.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb0[r_x] <= r_lb1[r_x];
      r_lb1[r_x] <= pixel_in;
      r_win_thr  <= threshold;
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
        r_win[r][2] <= w_col[r];
      end
    end
  end

  always_comb begin
    w_gx = wsum(r_win[0][2], r_win[1][2], r_win[2][2]) - wsum(r_win[0][0], r_win[1][0], r_win[2][0]);
    w_gy = wsum(r_win[2][0], r_win[2][1], r_win[2][2]) - wsum(r_win[0][0], r_win[0][1], r_win[0][2]);
  end

  always_ff @(posedge clk) begin
    r_gx     <= w_gx;
    r_gy     <= w_gy;
    r_s1_thr <= r_win_thr;
  end

  // Valid pipeline; vsync squashes every in-flight result, including the one about to reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid <= 1'b0;
      r_s1_valid  <= 1'b0;
    end else begin
      r_win_valid <= w_accept & w_interior;
      r_s1_valid  <= r_win_valid & ~vsync;
    end
  end

  always_comb begin
    w_abs_gx = r_gx[10] ? 11'(-r_gx) : 11'(r_gx);
    w_abs_gy = r_gy[10] ? 11'(-r_gy) : 11'(r_gy);
    w_mag    = w_abs_gx + w_abs_gy;
    w_sat    = (|w_mag[10:8]) ? 8'hFF : w_mag[7:0];
    w_over   = (w_mag > {3'b000, r_s1_thr});
  end

`ifdef SOBEL_DIR_EN
  logic [1:0] w_dir;

  always_comb begin
    w_dir = 2'd3;
    if ({w_abs_gy, 1'b0} <= {1'b0, w_abs_gx})      w_dir = 2'd0;
    else if ({w_abs_gx, 1'b0} <= {1'b0, w_abs_gy}) w_dir = 2'd1;
    else if (r_gx[10] == r_gy[10])                 w_dir = 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       edge_dir <= 2'd0;
    else if (r_s1_valid && !vsync)    edge_dir <= w_dir;
    else                              edge_dir <= 2'd0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_valid <= 1'b0;
      edge_out   <= 8'd0;
      edge_bit   <= 1'b0;
    end else if (r_s1_valid && !vsync) begin
      edge_valid <= 1'b1;
      edge_out   <= w_sat;
      edge_bit   <= w_over;
    end else begin
      edge_valid <= 1'b0;
      edge_out   <= 8'd0;
      edge_bit   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_3x3_edge_gray8.sv
// Scoreboard bench for sobel_3x3_edge_gray8 on a reduced 16x8 frame: flat, step, ramp, gapped input,
// mid-frame vsync and mid-frame reset. Expected results come from a direct Sobel model of the driven image.
module tb_sobel_3x3_edge_gray8;
  localparam int W    = 16;
  localparam int H    = 8;
  localparam int CW   = 4;
  localparam int NOUT = (W - 2) * (H - 2);

  logic       clk = 1'b0;
  logic       rst_n, vsync, pixel_valid;
  logic [7:0] pixel_in, threshold;
  logic       edge_valid, edge_bit;
  logic [7:0] edge_out;
`ifdef SOBEL_DIR_EN
  logic [1:0] edge_dir;
`endif

  sobel_3x3_edge_gray8 #(.IMG_W(W), .IMG_H(H), .COORD_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .pixel_valid (pixel_valid),
    .pixel_in    (pixel_in),
    .threshold   (threshold),
    .edge_valid  (edge_valid),
    .edge_out    (edge_out),
    .edge_bit    (edge_bit)
`ifdef SOBEL_DIR_EN
    ,
    .edge_dir    (edge_dir)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic       bit_;
    logic [1:0] dir;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] img [H][W];
  int         checks = 0, failures = 0, cyc = 0, n_valid = 0, n_bit = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input int x, input int y, input logic [7:0] thr, input int c);
    exp_t e;
    int gx, gy, ax, ay, mag;
    gx = int'(img[y-2][x]) + 2*int'(img[y-1][x]) + int'(img[y][x])
       - int'(img[y-2][x-2]) - 2*int'(img[y-1][x-2]) - int'(img[y][x-2]);
    gy = int'(img[y][x-2]) + 2*int'(img[y][x-1]) + int'(img[y][x])
       - int'(img[y-2][x-2]) - 2*int'(img[y-2][x-1]) - int'(img[y-2][x]);
    ax  = (gx < 0) ? -gx : gx;
    ay  = (gy < 0) ? -gy : gy;
    mag = ax + ay;
    e.out  = (mag > 255) ? 8'd255 : 8'(mag);
    e.bit_ = (mag > int'(thr));
    if (2*ay <= ax)                    e.dir = 2'd0;
    else if (2*ax <= ay)               e.dir = 2'd1;
    else if ((gx < 0) == (gy < 0))     e.dir = 2'd2;
    else                               e.dir = 2'd3;
    e.cyc = c;
    return e;
  endfunction

  // Output monitor: samples on the falling edge, pops the scoreboard on each valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (edge_valid === 1'b1) begin
        n_valid++;
        if (edge_bit === 1'b1) n_bit++;
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("edge_out", 32'(edge_out), 32'(e.out));
          check("edge_bit", 32'(edge_bit), 32'(e.bit_));
          check("latency", 32'(cyc), 32'(e.cyc));
`ifdef SOBEL_DIR_EN
          check("edge_dir", 32'(edge_dir), 32'(e.dir));
`endif
        end
      end else begin
        check("idle_valid", 32'(edge_valid), 32'd0);
        check("idle_data", {23'd0, edge_out, edge_bit}, 32'd0);
      end
    end
  end

  function automatic logic [7:0] pattern(input int pat, input int x);
    case (pat)
      0:       return 8'd128;
      1:       return (x < W/2) ? 8'd0 : 8'd200;
      default: return 8'(x);
    endcase
  endfunction

  task automatic idle();
    pixel_valid = 1'b0;
    pixel_in    = 8'($urandom);
    threshold   = 8'($urandom);
    @(negedge clk);
  endtask

  task automatic send(input int x, input int y, input logic [7:0] thr);
    pixel_valid = 1'b1;
    pixel_in    = img[y][x];
    threshold   = thr;
    if (x >= 2 && y >= 2) sb.push_back(model(x, y, thr, cyc + 3));
    @(negedge clk);
  endtask

  // Sends rows [0, y_end) fully, then row y_end up to column x_end-1.
  task automatic frame(input int pat, input logic [7:0] thr, input bit gaps, input int y_end, input int x_end);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = pattern(pat, x);
    for (int y = 0; y <= y_end && y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (y == y_end && x >= x_end) break;
        if (gaps) repeat ($urandom_range(0, 2)) idle();
        send(x, y, thr);
      end
    pixel_valid = 1'b0;
  endtask

  task automatic full_frame(input int pat, input logic [7:0] thr, input bit gaps);
    frame(pat, thr, gaps, H, 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; vsync = 1'b0; pixel_valid = 1'b0; pixel_in = 8'd0; threshold = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(edge_valid), 32'd0);
    check("reset_data", {23'd0, edge_out, edge_bit}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Flat frame: all zero magnitude; threshold 0 checks the strict compare.
    n_valid = 0; n_bit = 0;
    full_frame(0, 8'd0, 1'b0);
    drain("flat_drain");
    check("flat_count", 32'(n_valid), 32'(NOUT));
    check("flat_bits", 32'(n_bit), 32'd0);

    // Step frame, continuous, directly after the previous frame (counter self-wrap).
    n_valid = 0; n_bit = 0;
    full_frame(1, 8'd50, 1'b0);
    drain("step_drain");
    check("step_count", 32'(n_valid), 32'(NOUT));
    check("step_bits", 32'(n_bit), 32'(2 * (H - 2)));

    // Ramp: magnitude 8 everywhere, straddling the threshold.
    n_valid = 0; n_bit = 0;
    full_frame(2, 8'd7, 1'b0);
    drain("ramp7_drain");
    check("ramp7_bits", 32'(n_bit), 32'(NOUT));
    n_valid = 0; n_bit = 0;
    full_frame(2, 8'd8, 1'b0);
    drain("ramp8_drain");
    check("ramp8_bits", 32'(n_bit), 32'd0);

    // Step frame with random input gaps.
    n_valid = 0; n_bit = 0;
    full_frame(1, 8'd50, 1'b1);
    drain("gap_drain");
    check("gap_count", 32'(n_valid), 32'(NOUT));
    check("gap_bits", 32'(n_bit), 32'(2 * (H - 2)));

    // Mid-frame vsync: pixels offered during vsync must be dropped, in-flight results squashed.
    frame(1, 8'd50, 1'b0, 4, 7);
    vsync = 1'b1; pixel_valid = 1'b1; pixel_in = 8'd255;
    #1;
    while (sb.size() != 0 && sb[sb.size()-1].cyc > cyc) void'(sb.pop_back());
    n_valid = 0;
    repeat (2) @(negedge clk);
    vsync = 1'b0; pixel_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("vsync_no_valid", 32'(n_valid), 32'd0);
    n_valid = 0; n_bit = 0;
    full_frame(0, 8'd10, 1'b0);
    drain("vsync_drain");
    check("vsync_next_count", 32'(n_valid), 32'(NOUT));

    // Mid-frame asynchronous reset, then vsync and a clean step frame.
    frame(1, 8'd50, 1'b0, 3, 9);
    pixel_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("async_rst_valid", 32'(edge_valid), 32'd0);
    check("async_rst_data", {23'd0, edge_out, edge_bit}, 32'd0);
    repeat (3) @(negedge clk);
    pixel_valid = 1'b0;
    rst_n = 1'b1; vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    n_valid = 0; n_bit = 0;
    full_frame(1, 8'd50, 1'b0);
    drain("rst_drain");
    check("rst_step_count", 32'(n_valid), 32'(NOUT));
    check("rst_step_bits", 32'(n_bit), 32'(2 * (H - 2)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
